// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - PS/2 set-2 prefix decoder feeding a show-ahead scancode FIFO
// Prefix bytes (E0/F0) fold into per-entry flags; 00/FF receiver error codes are discarded.
module kbd_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            ps2_data,
  input  logic                  ps2_hit,
  input  logic                  rd,
  input  logic                  clr,
  output logic [7:0]            kb_data,
  output logic [1:0]            kb_flags,
  output logic [DEPTH_LOG2:0]   kb_count,
  output logic [7:0]            kb_status
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXT    = 2'd1,
    REL    = 2'd2,
    EXTREL = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [9:0]              mem_q [DEPTH];

  logic                    is_e0, is_f0, is_err;
  logic                    push_req;
  logic [1:0]              push_flags;
  logic                    empty, full;
  logic                    do_pop, do_push;

  assign is_e0  = (ps2_data == 8'hE0);
  assign is_f0  = (ps2_data == 8'hF0);
  assign is_err = (ps2_data == 8'h00) || (ps2_data == 8'hFF);

  always_comb begin
    state_d    = state_q;
    push_req   = 1'b0;
    push_flags = 2'b00;
    if (ps2_hit) begin
      unique case (state_q)
        IDLE: begin
          if (is_e0)       state_d = EXT;
          else if (is_f0)  state_d = REL;
          else if (!is_err) push_req = 1'b1;
        end
        EXT: begin
          if (is_f0)       state_d = EXTREL;
          else if (is_e0)  state_d = EXT;
          else begin
            state_d    = IDLE;
            push_req   = !is_err;
            push_flags = 2'b10;
          end
        end
        REL: begin
          if (is_e0)       state_d = EXTREL;
          else if (is_f0)  state_d = REL;
          else begin
            state_d    = IDLE;
            push_req   = !is_err;
            push_flags = 2'b01;
          end
        end
        EXTREL: begin
          if (is_e0 || is_f0) state_d = EXTREL;
          else begin
            state_d    = IDLE;
            push_req   = !is_err;
            push_flags = 2'b11;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Flush wins over any byte arriving in the same cycle.
    if (clr) begin
      state_d  = IDLE;
      push_req = 1'b0;
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_pop  = rd && !empty && !clr;
  assign do_push = push_req && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
      if (push_req && !do_push)    ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_flags, ps2_data};
  end

  // Head is masked while empty so every output reads zero straight out of reset.
  assign kb_data   = empty ? 8'h00 : mem_q[rd_ptr_q][7:0];
  assign kb_flags  = empty ? 2'b00 : mem_q[rd_ptr_q][9:8];
  assign kb_count  = count_q;
  assign kb_status = {!empty, ovf_q, full, 5'b00000};

endmodule
